flexbex_ibex_irq_arbiter: RTL and testbench



---
 rtl/flexbex_ibex_irq_arbiter.sv | 127 ++++++++++++
 tb/tb_flexbex_ibex_irq_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_ibex_irq_arbiter.sv
// flexbex_ibex_irq_arbiter
// Collects NUM_IRQ interrupt lines, tracks pending/enable/in-service state
// per line and presents one fixed-priority request that stays stable until
// the core acknowledges it or the request is withdrawn.
module flexbex_ibex_irq_arbiter #(
    parameter int          NUM_IRQ   = 32,
    parameter logic [31:0] EDGE_MASK = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_lines_i,
    input  logic               en_we_i,
    input  logic [NUM_IRQ-1:0] en_wdata_i,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    input  logic               ack_i,
    input  logic [4:0]         ack_id_i,
    input  logic               complete_i,
    input  logic [4:0]         complete_id_i,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic [NUM_IRQ-1:0] in_service_o
);

    localparam logic [NUM_IRQ-1:0] EDGE_BITS = EDGE_MASK[NUM_IRQ-1:0];

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] line_q;
    logic [NUM_IRQ-1:0] ack_vec, complete_vec;
    logic [NUM_IRQ-1:0] eligible;
    logic [31:0]        eligible_ext;
    logic [4:0]         winner_id;
    logic               winner_found;

    // Decode ack/complete ids to one-hot vectors; ids >= NUM_IRQ decode to nothing
    always_comb begin
        ack_vec      = '0;
        complete_vec = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            ack_vec[i]      = ack_i && (32'(ack_id_i) == i);
            complete_vec[i] = complete_i && (32'(complete_id_i) == i);
        end
    end

    // Next pending (level follows line, edge is sticky until acked; set wins) and in-service (ack wins)
    always_comb begin
        pending_d    = (irq_lines_i & ~EDGE_BITS)
                     | (EDGE_BITS & ((irq_lines_i & ~line_q) | (pending_q & ~ack_vec)));
        in_service_d = (in_service_q & ~complete_vec) | ack_vec;
    end

    // Eligible set and lowest-index winner
    always_comb begin
        eligible     = pending_q & enable_q & ~in_service_q;
        winner_id    = '0;
        winner_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!winner_found && eligible[i]) begin
                winner_id    = 5'(i);
                winner_found = 1'b1;
            end
        end
    end

    // Zero-extended eligible vector so the 5-bit presented id can index it for any NUM_IRQ
    always_comb begin
        eligible_ext              = '0;
        eligible_ext[NUM_IRQ-1:0] = eligible;
    end

    // Request FSM next-state: latch winner on entry to REQ, hold id while presenting
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d  = REQ;
                    irq_id_d = winner_id;
                end
            end
            REQ: begin
                if (ack_i) begin
                    state_d = IDLE;
                end else if (!eligible_ext[irq_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and per-line registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_id_q     <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            line_q       <= irq_lines_i;
            if (en_we_i) begin
                enable_q <= en_wdata_i;
            end
        end
    end

    assign irq_o        = (state_q == REQ);
    assign irq_id_o     = irq_id_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: tb/tb_flexbex_ibex_irq_arbiter.sv
// Testbench for flexbex_ibex_irq_arbiter: directed scenarios plus a
// randomized phase, checked against a per-line behavioural model.
module tb_flexbex_ibex_irq_arbiter;

    localparam int          N  = 16;
    localparam logic [31:0] EM = 32'h0000_0120;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_lines_i;
    logic         en_we_i;
    logic [N-1:0] en_wdata_i;
    logic         irq_o;
    logic [4:0]   irq_id_o;
    logic         ack_i;
    logic [4:0]   ack_id_i;
    logic         complete_i;
    logic [4:0]   complete_id_i;
    logic [N-1:0] pending_o;
    logic [N-1:0] in_service_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state, one entry per line
    bit          m_pend[N];
    bit          m_en[N];
    bit          m_ins[N];
    bit          m_prev[N];
    bit          m_req;
    int          m_id;
    logic [31:0] edge_cfg;

    flexbex_ibex_irq_arbiter #(
        .NUM_IRQ  (N),
        .EDGE_MASK(EM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_lines_i  (irq_lines_i),
        .en_we_i      (en_we_i),
        .en_wdata_i   (en_wdata_i),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .ack_i        (ack_i),
        .ack_id_i     (ack_id_i),
        .complete_i   (complete_i),
        .complete_id_i(complete_id_i),
        .pending_o    (pending_o),
        .in_service_o (in_service_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    // Apply one clock edge's worth of the interrupt rules to the model
    task automatic model_edge();
        bit elig[N];
        int win;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_ins[i] = 0; m_prev[i] = 0;
            end
            m_req = 0;
            m_id  = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < N; i++) begin
            elig[i] = m_pend[i] && m_en[i] && !m_ins[i];
            if (win < 0 && elig[i]) win = i;
        end
        if (!m_req) begin
            if (win >= 0) begin
                m_req = 1;
                m_id  = win;
            end
        end else if (ack_i) begin
            m_req = 0;
        end else if (!elig[m_id]) begin
            m_req = 0;
        end
        for (int i = 0; i < N; i++) begin
            bit acked;
            acked = ack_i && (int'(ack_id_i) == i);
            if (edge_cfg[i]) begin
                if (irq_lines_i[i] && !m_prev[i]) m_pend[i] = 1;
                else if (acked) m_pend[i] = 0;
            end else begin
                m_pend[i] = irq_lines_i[i];
            end
            if (complete_i && int'(complete_id_i) == i) m_ins[i] = 0;
            if (acked) m_ins[i] = 1;
            if (en_we_i) m_en[i] = en_wdata_i[i];
            m_prev[i] = irq_lines_i[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("irq_o", 32'(irq_o), 32'(m_req));
        if (m_req) chk("irq_id_o", 32'(irq_id_o), 32'(m_id));
        chk("pending_o", 32'(pending_o), 32'(pack(m_pend)));
        chk("in_service_o", 32'(in_service_o), 32'(pack(m_ins)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        edge_cfg      = EM;
        rst           = 1'b1;
        irq_lines_i   = '0;
        en_we_i       = 1'b0;
        en_wdata_i    = '0;
        ack_i         = 1'b0;
        ack_id_i      = '0;
        complete_i    = 1'b0;
        complete_id_i = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_ins[i] = 0; m_prev[i] = 0;
        end
        m_req = 0;
        m_id  = 0;

        // Reset state
        steps(2);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_id", 32'(irq_id_o), 32'd0);
        chk("rst_pend", 32'(pending_o), 32'd0);
        rst = 1'b0;
        steps(2);

        // Level line 3
        en_we_i = 1'b1; en_wdata_i = 16'h0008;
        step();
        en_we_i = 1'b0;
        irq_lines_i[3] = 1'b1;
        step();
        chk("lvl_pend3", 32'(pending_o[3]), 32'd1);
        chk("lvl_noreq_yet", 32'(irq_o), 32'd0);
        step();
        chk("lvl_irq", 32'(irq_o), 32'd1);
        chk("lvl_id", 32'(irq_id_o), 32'd3);
        ack_i = 1'b1; ack_id_i = 5'd3;
        step();
        ack_i = 1'b0;
        chk("lvl_ack_drop", 32'(irq_o), 32'd0);
        chk("lvl_ins", 32'(in_service_o), 32'h8);
        steps(3);
        chk("lvl_no_rereq", 32'(irq_o), 32'd0);
        complete_i = 1'b1; complete_id_i = 5'd3;
        step();
        complete_i = 1'b0;
        chk("lvl_cpl_ins", 32'(in_service_o), 32'h0);
        chk("lvl_cpl_gap", 32'(irq_o), 32'd0);
        step();
        chk("lvl_rereq", 32'(irq_o), 32'd1);
        chk("lvl_rereq_id", 32'(irq_id_o), 32'd3);
        irq_lines_i = '0;
        steps(3);

        // Priority and stability
        en_we_i = 1'b1; en_wdata_i = 16'hFFFF;
        step();
        en_we_i = 1'b0;
        irq_lines_i[7] = 1'b1;
        steps(2);
        chk("pri_id7", 32'(irq_id_o), 32'd7);
        irq_lines_i[2] = 1'b1;
        step();
        chk("pri_hold7a", 32'(irq_id_o), 32'd7);
        step();
        chk("pri_hold7b", 32'(irq_id_o), 32'd7);
        chk("pri_irq_held", 32'(irq_o), 32'd1);
        ack_i = 1'b1; ack_id_i = 5'd7;
        step();
        ack_i = 1'b0;
        chk("pri_gap", 32'(irq_o), 32'd0);
        step();
        chk("pri_irq2", 32'(irq_o), 32'd1);
        chk("pri_id2", 32'(irq_id_o), 32'd2);
        irq_lines_i = '0;
        ack_i = 1'b1; ack_id_i = 5'd2;
        step();
        ack_i = 1'b0;
        complete_i = 1'b1; complete_id_i = 5'd2;
        step();
        complete_id_i = 5'd7;
        step();
        complete_i = 1'b0;
        steps(2);

        // Edge line 5
        irq_lines_i[5] = 1'b1;
        step();
        irq_lines_i[5] = 1'b0;
        step();
        chk("edge_sticky", 32'(pending_o[5]), 32'd1);
        step();
        chk("edge_irq_id", 32'(irq_id_o), 32'd5);
        ack_i = 1'b1; ack_id_i = 5'd5;
        step();
        ack_i = 1'b0;
        chk("edge_ack_clr", 32'(pending_o[5]), 32'd0);
        complete_i = 1'b1; complete_id_i = 5'd5;
        step();
        complete_i = 1'b0;
        irq_lines_i[5] = 1'b1;
        ack_i = 1'b1; ack_id_i = 5'd5;
        step();
        ack_i = 1'b0;
        irq_lines_i[5] = 1'b0;
        chk("edge_set_wins", 32'(pending_o[5]), 32'd1);
        complete_i = 1'b1; complete_id_i = 5'd5;
        step();
        complete_i = 1'b0;
        steps(2);
        ack_i = 1'b1; ack_id_i = 5'd5;
        step();
        ack_i = 1'b0;
        complete_i = 1'b1; complete_id_i = 5'd5;
        step();
        complete_i = 1'b0;
        steps(2);

        // Withdraw by disable
        irq_lines_i[4] = 1'b1;
        steps(2);
        chk("wd_irq", 32'(irq_o), 32'd1);
        chk("wd_id4", 32'(irq_id_o), 32'd4);
        en_we_i = 1'b1; en_wdata_i = 16'h0000;
        step();
        en_we_i = 1'b0;
        step();
        chk("wd_drop", 32'(irq_o), 32'd0);
        chk("wd_pend4", 32'(pending_o[4]), 32'd1);
        en_we_i = 1'b1; en_wdata_i = 16'hFFFF;
        step();
        en_we_i = 1'b0;
        step();
        chk("wd_resume", 32'(irq_o), 32'd1);
        chk("wd_resume_id", 32'(irq_id_o), 32'd4);
        irq_lines_i = '0;
        ack_i = 1'b1; ack_id_i = 5'd4;
        step();
        ack_i = 1'b0;
        complete_i = 1'b1; complete_id_i = 5'd4;
        step();
        complete_i = 1'b0;
        steps(2);

        // Ack/complete collision and out-of-range ids
        ack_i = 1'b1; ack_id_i = 5'd6;
        complete_i = 1'b1; complete_id_i = 5'd6;
        step();
        chk("coll_ack_wins", 32'(in_service_o), 32'h0040);
        ack_id_i = 5'd31;
        complete_id_i = 5'd22;
        step();
        ack_i = 1'b0;
        chk("oor_nochange", 32'(in_service_o), 32'h0040);
        complete_id_i = 5'd6;
        step();
        complete_i = 1'b0;
        chk("coll_cpl", 32'(in_service_o), 32'h0000);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0)
                irq_lines_i = irq_lines_i ^ (N'(1) << $urandom_range(0, N - 1));
            en_we_i    = ($urandom_range(0, 15) == 0);
            en_wdata_i = N'($urandom);
            if (m_req && $urandom_range(0, 2) == 0) begin
                ack_i    = 1'b1;
                ack_id_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(m_id);
            end else if ($urandom_range(0, 19) == 0) begin
                ack_i    = 1'b1;
                ack_id_i = 5'($urandom);
            end else begin
                ack_i = 1'b0;
            end
            complete_i    = ($urandom_range(0, 3) == 0);
            complete_id_i = 5'($urandom);
            step();
        end
        irq_lines_i = '0;
        en_we_i     = 1'b0;
        ack_i       = 1'b0;
        complete_i  = 1'b0;

        // Reset during an active request
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_we_i = 1'b1; en_wdata_i = 16'hFFFF;
        step();
        en_we_i = 1'b0;
        irq_lines_i[1] = 1'b1;
        steps(2);
        chk("mid_irq", 32'(irq_o), 32'd1);
        chk("mid_id1", 32'(irq_id_o), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_irq", 32'(irq_o), 32'd0);
        chk("mid_rst_id", 32'(irq_id_o), 32'd0);
        chk("mid_rst_pend", 32'(pending_o), 32'd0);
        chk("mid_rst_ins", 32'(in_service_o), 32'd0);
        rst = 1'b0;
        steps(4);
        chk("post_rst_noreq", 32'(irq_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
